id_ctrl: RTL

Decode-stage controller for the 3-stage RV32I pipeline. It owns the ID pipeline register and the ID→EX control register. Each cycle it decodes the ID instruction into the immediate-format select for the immediate generator, plus EX-stage control. It also sequences the pipeline: load-use stall with bubble insertion, branch/jump flush, global memory freeze, and a bubble counter.

---
 rtl/id_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/id_ctrl.sv
// Decode-stage controller: owns the ID pipeline register and the ID->EX control
// register, decodes immediate format / EX class, and sequences stall, flush and bubbles.
module id_ctrl #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_i,
  input  logic             instr_valid_i,
  input  logic             flush_i,
  input  logic             mem_stall_i,
  output logic             stall_o,
  output logic [1:0]       id_imm_sel_o,
  output logic             id_valid_o,
  output logic             ex_valid_o,
  output logic [31:0]      ex_instr_o,
  output logic [1:0]       ex_imm_sel_o,
  output logic [4:0]       ex_rd_o,
  output logic             ex_reg_we_o,
  output logic             ex_is_load_o,
  output logic             ex_is_store_o,
  output logic             ex_is_branch_o,
  output logic             ex_is_jal_o,
  output logic             ex_illegal_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic [31:0]      id_instr_q, id_instr_d;
  logic             id_valid_q, id_valid_d;
  logic             ex_valid_q, ex_valid_d;
  logic [31:0]      ex_instr_q, ex_instr_d;
  logic [1:0]       ex_imm_sel_q, ex_imm_sel_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic             ex_reg_we_q, ex_reg_we_d;
  logic             ex_is_load_q, ex_is_load_d;
  logic             ex_is_store_q, ex_is_store_d;
  logic             ex_is_branch_q, ex_is_branch_d;
  logic             ex_is_jal_q, ex_is_jal_d;
  logic             ex_illegal_q, ex_illegal_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic [1:0] dec_imm_sel;
  logic       dec_we, dec_load, dec_store, dec_branch, dec_jal, dec_illegal;
  logic       dec_rs1_used, dec_rs2_used;
  logic [4:0] id_rd, id_rs1, id_rs2;
  logic       hazard;

  assign id_rd  = id_instr_q[11:7];
  assign id_rs1 = id_instr_q[19:15];
  assign id_rs2 = id_instr_q[24:20];

  always_comb begin
    dec_imm_sel  = 2'b00;
    dec_we       = 1'b0;
    dec_load     = 1'b0;
    dec_store    = 1'b0;
    dec_branch   = 1'b0;
    dec_jal      = 1'b0;
    dec_illegal  = 1'b0;
    dec_rs1_used = 1'b1;
    dec_rs2_used = 1'b0;
    unique case (id_instr_q[6:0])
      OPC_OP_IMM, OPC_JALR: dec_we = 1'b1;
      OPC_LOAD: begin
        dec_we   = 1'b1;
        dec_load = 1'b1;
      end
      OPC_STORE: begin
        dec_imm_sel  = 2'b01;
        dec_store    = 1'b1;
        dec_rs2_used = 1'b1;
      end
      OPC_BRANCH: begin
        dec_imm_sel  = 2'b10;
        dec_branch   = 1'b1;
        dec_rs2_used = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_imm_sel  = 2'b11;
        dec_we       = 1'b1;
        dec_rs1_used = 1'b0;
      end
      OPC_OP: begin
        dec_we       = 1'b1;
        dec_rs2_used = 1'b1;
      end
      OPC_JAL: begin
        dec_we       = 1'b1;
        dec_jal      = 1'b1;
        dec_rs1_used = 1'b0;
      end
      default: begin
        dec_illegal  = 1'b1;
        dec_rs1_used = 1'b0;
      end
    endcase
  end

  // A load in EX whose rd feeds the ID instruction needs one bubble; x0 never hazards.
  assign hazard = id_valid_q & ex_valid_q & ex_is_load_q & (ex_rd_q != 5'd0) &
                  ((dec_rs1_used & (id_rs1 == ex_rd_q)) |
                   (dec_rs2_used & (id_rs2 == ex_rd_q)));

  assign stall_o = mem_stall_i | (hazard & ~flush_i);

  always_comb begin
    id_instr_d     = id_instr_q;
    id_valid_d     = id_valid_q;
    ex_valid_d     = ex_valid_q;
    ex_instr_d     = ex_instr_q;
    ex_imm_sel_d   = ex_imm_sel_q;
    ex_rd_d        = ex_rd_q;
    ex_reg_we_d    = ex_reg_we_q;
    ex_is_load_d   = ex_is_load_q;
    ex_is_store_d  = ex_is_store_q;
    ex_is_branch_d = ex_is_branch_q;
    ex_is_jal_d    = ex_is_jal_q;
    ex_illegal_d   = ex_illegal_q;
    bubble_cnt_d   = bubble_cnt_q;
    if (!mem_stall_i) begin
      if (flush_i || hazard) begin
        ex_valid_d     = 1'b0;
        ex_instr_d     = NOP_INSTR;
        ex_imm_sel_d   = 2'b00;
        ex_rd_d        = 5'd0;
        ex_reg_we_d    = 1'b0;
        ex_is_load_d   = 1'b0;
        ex_is_store_d  = 1'b0;
        ex_is_branch_d = 1'b0;
        ex_is_jal_d    = 1'b0;
        ex_illegal_d   = 1'b0;
        if (flush_i) begin
          id_instr_d = NOP_INSTR;
          id_valid_d = 1'b0;
        end else begin
          bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
      end else begin
        id_instr_d     = instr_i;
        id_valid_d     = instr_valid_i;
        ex_valid_d     = id_valid_q;
        ex_instr_d     = id_instr_q;
        ex_imm_sel_d   = dec_imm_sel;
        ex_rd_d        = id_rd;
        ex_reg_we_d    = id_valid_q & dec_we & (id_rd != 5'd0);
        ex_is_load_d   = id_valid_q & dec_load;
        ex_is_store_d  = id_valid_q & dec_store;
        ex_is_branch_d = id_valid_q & dec_branch;
        ex_is_jal_d    = id_valid_q & dec_jal;
        ex_illegal_d   = id_valid_q & dec_illegal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_instr_q     <= NOP_INSTR;
      id_valid_q     <= 1'b0;
      ex_valid_q     <= 1'b0;
      ex_instr_q     <= NOP_INSTR;
      ex_imm_sel_q   <= 2'b00;
      ex_rd_q        <= 5'd0;
      ex_reg_we_q    <= 1'b0;
      ex_is_load_q   <= 1'b0;
      ex_is_store_q  <= 1'b0;
      ex_is_branch_q <= 1'b0;
      ex_is_jal_q    <= 1'b0;
      ex_illegal_q   <= 1'b0;
      bubble_cnt_q   <= '0;
    end else begin
      id_instr_q     <= id_instr_d;
      id_valid_q     <= id_valid_d;
      ex_valid_q     <= ex_valid_d;
      ex_instr_q     <= ex_instr_d;
      ex_imm_sel_q   <= ex_imm_sel_d;
      ex_rd_q        <= ex_rd_d;
      ex_reg_we_q    <= ex_reg_we_d;
      ex_is_load_q   <= ex_is_load_d;
      ex_is_store_q  <= ex_is_store_d;
      ex_is_branch_q <= ex_is_branch_d;
      ex_is_jal_q    <= ex_is_jal_d;
      ex_illegal_q   <= ex_illegal_d;
      bubble_cnt_q   <= bubble_cnt_d;
    end
  end

  assign id_imm_sel_o   = dec_imm_sel;
  assign id_valid_o     = id_valid_q;
  assign ex_valid_o     = ex_valid_q;
  assign ex_instr_o     = ex_instr_q;
  assign ex_imm_sel_o   = ex_imm_sel_q;
  assign ex_rd_o        = ex_rd_q;
  assign ex_reg_we_o    = ex_reg_we_q;
  assign ex_is_load_o   = ex_is_load_q;
  assign ex_is_store_o  = ex_is_store_q;
  assign ex_is_branch_o = ex_is_branch_q;
  assign ex_is_jal_o    = ex_is_jal_q;
  assign ex_illegal_o   = ex_illegal_q;
  assign bubble_cnt_o   = bubble_cnt_q;

endmodule
